// File: rtl/gpu_pkg.sv
// Shared state encodings and arithmetic helper for the kernel block dispatcher.
package gpu_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } dispatch_state_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESET = 2'd1,
    S_BUSY  = 2'd2
  } slot_state_e;

  // ceil(num / 2**shift): a shift plus one when any remainder bit is set
  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned shift);
    int unsigned mask;
    mask = (32'd1 << shift) - 32'd1;
    return (num >> shift) + (((num & mask) != 32'd0) ? 32'd1 : 32'd0);
  endfunction

endpackage

// File: rtl/dispatch_slot.sv
// One core's dispatch slot: a one-cycle core reset, then a run request held
// until the core reports its block complete.
module dispatch_slot
  import gpu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned TC_WIDTH   = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_dispatch,
  input  logic [DATA_WIDTH-1:0] i_block_id,
  input  logic [TC_WIDTH-1:0]   i_thread_count,
  input  logic                  i_core_done,
  output logic                  o_core_reset,
  output logic                  o_core_start,
  output logic [DATA_WIDTH-1:0] o_block_id,
  output logic [TC_WIDTH-1:0]   o_thread_count,
  output logic                  o_idle_c,
  output logic                  o_done_pulse_c
);

  slot_state_e           r_state;
  slot_state_e           w_next_state;
  logic                  w_load;
  logic                  r_core_reset;
  logic                  r_core_start;
  logic [DATA_WIDTH-1:0] r_block_id;
  logic [TC_WIDTH-1:0]   r_thread_count;

  // Next-state logic; core_done only matters while the core is running
  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_dispatch) begin
          w_next_state = S_RESET;
          w_load       = 1'b1;
        end
      end
      S_RESET: w_next_state = S_BUSY;
      S_BUSY: begin
        if (i_core_done) begin
          w_next_state = S_IDLE;
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Handshake outputs follow the registered state; ID/count hold after completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= S_IDLE;
      r_core_reset   <= 1'b0;
      r_core_start   <= 1'b0;
      r_block_id     <= '0;
      r_thread_count <= '0;
    end else begin
      r_state      <= w_next_state;
      r_core_reset <= (w_next_state == S_RESET);
      r_core_start <= (w_next_state == S_BUSY);
      if (w_load) begin
        r_block_id     <= i_block_id;
        r_thread_count <= i_thread_count;
      end
    end
  end

  assign o_core_reset   = r_core_reset;
  assign o_core_start   = r_core_start;
  assign o_block_id     = r_block_id;
  assign o_thread_count = r_thread_count;
  assign o_idle_c       = (r_state == S_IDLE);
  assign o_done_pulse_c = (r_state == S_BUSY) && i_core_done;

endmodule

// File: rtl/block_dispatcher.sv
// Splits a launched kernel's thread count into fixed-size blocks and hands them
// to idle compute cores, raising done once every block has completed.
module block_dispatcher
  import gpu_pkg::*;
#(
  parameter int unsigned  DATA_WIDTH        = 8,
  parameter int unsigned  NUM_CORES         = 2,
  parameter int unsigned  THREADS_PER_BLOCK = 4,
  localparam int unsigned TC_WIDTH          = $clog2(THREADS_PER_BLOCK) + 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 start,
  input  logic [DATA_WIDTH-1:0]                thread_count,
  input  logic [NUM_CORES-1:0]                 core_done,
  output logic [NUM_CORES-1:0]                 core_reset,
  output logic [NUM_CORES-1:0]                 core_start,
  output logic [NUM_CORES-1:0][DATA_WIDTH-1:0] core_block_id,
  output logic [NUM_CORES-1:0][TC_WIDTH-1:0]   core_thread_count,
  output logic                                 done
);

  localparam int unsigned BLK_SHIFT = $clog2(THREADS_PER_BLOCK);

  dispatch_state_e       r_state;
  dispatch_state_e       w_next_state;
  logic [DATA_WIDTH-1:0] r_tc_q;
  logic [DATA_WIDTH-1:0] w_tc_q;
  logic [DATA_WIDTH-1:0] r_total_blocks;
  logic [DATA_WIDTH-1:0] w_total_blocks;
  logic [DATA_WIDTH-1:0] r_next_block;
  logic [DATA_WIDTH-1:0] w_next_block;
  logic [DATA_WIDTH-1:0] r_blocks_done;
  logic [DATA_WIDTH-1:0] w_blocks_done;
  logic                  r_done;
  logic                  w_dispatch;

  logic [NUM_CORES-1:0]  w_idle;
  logic [NUM_CORES-1:0]  w_done_pulse;
  logic [NUM_CORES-1:0]  w_grant;
  logic [NUM_CORES-1:0]  w_dispatch_vec;
  logic [DATA_WIDTH-1:0] w_done_cnt;
  logic [DATA_WIDTH-1:0] w_remain;
  logic [TC_WIDTH-1:0]   w_blk_tc;

  // Lowest-index idle slot wins: isolate the least significant set bit
  assign w_grant        = w_idle & (~w_idle + NUM_CORES'(1));
  assign w_dispatch_vec = w_dispatch ? w_grant : '0;

  // Threads left from the next block onward; only the last block can be partial
  assign w_remain = r_tc_q - (r_next_block << BLK_SHIFT);
  assign w_blk_tc = (w_remain >= DATA_WIDTH'(THREADS_PER_BLOCK)) ?
                    TC_WIDTH'(THREADS_PER_BLOCK) : TC_WIDTH'(w_remain);

  // Several slots may complete in one cycle
  always_comb begin
    w_done_cnt = '0;
    for (int i = 0; i < NUM_CORES; i++) begin
      w_done_cnt = w_done_cnt + DATA_WIDTH'(w_done_pulse[i]);
    end
  end

  // Kernel FSM and its counters
  always_comb begin
    w_next_state   = r_state;
    w_tc_q         = r_tc_q;
    w_total_blocks = r_total_blocks;
    w_next_block   = r_next_block;
    w_blocks_done  = r_blocks_done;
    w_dispatch     = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_next_state   = RUN;
          w_tc_q         = thread_count;
          w_total_blocks = DATA_WIDTH'(ceil_div(32'(thread_count), BLK_SHIFT));
          w_next_block   = '0;
          w_blocks_done  = '0;
        end
      end
      RUN: begin
        w_blocks_done = r_blocks_done + w_done_cnt;
        if (r_blocks_done == r_total_blocks) begin
          w_next_state = DONE;
        end else if ((r_next_block < r_total_blocks) && (|w_idle)) begin
          w_dispatch   = 1'b1;
          w_next_block = r_next_block + DATA_WIDTH'(1);
        end
      end
      DONE: begin
        if (!start) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_tc_q         <= '0;
      r_total_blocks <= '0;
      r_next_block   <= '0;
      r_blocks_done  <= '0;
      r_done         <= 1'b0;
    end else begin
      r_state        <= w_next_state;
      r_tc_q         <= w_tc_q;
      r_total_blocks <= w_total_blocks;
      r_next_block   <= w_next_block;
      r_blocks_done  <= w_blocks_done;
      r_done         <= (w_next_state == DONE);
    end
  end

  assign done = r_done;

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_slot
    dispatch_slot #(
      .DATA_WIDTH(DATA_WIDTH),
      .TC_WIDTH  (TC_WIDTH)
    ) u_slot (
      .clk           (clk),
      .rst_n         (rst_n),
      .i_dispatch    (w_dispatch_vec[g]),
      .i_block_id    (r_next_block),
      .i_thread_count(w_blk_tc),
      .i_core_done   (core_done[g]),
      .o_core_reset  (core_reset[g]),
      .o_core_start  (core_start[g]),
      .o_block_id    (core_block_id[g]),
      .o_thread_count(core_thread_count[g]),
      .o_idle_c      (w_idle[g]),
      .o_done_pulse_c(w_done_pulse[g])
    );
  end

endmodule
